delay_checker: RTL and testbench

Self-checking receiver for the N-cycle delay pipeline. It shadows every reference word written into the pipeline, delays it internally by DEPTH cycles, and compares it against the pipeline output at the matching edge. It counts checks and mismatches, and reports a pass/fail verdict after an explicit stop-and-drain sequence. It sits on the output side of the pipeline in on-chip self-test and in simulation harnesses.

---
 rtl/delay_checker.sv | 195 +++++++++++++++++++
 tb/tb_delay_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_checker.sv
// Self-checking receiver for a DEPTH-cycle delay pipeline: shadows reference words, compares, counts, reports.
// Optional first-mismatch capture is enabled by defining DELAY_CHECKER_FIRST_ERR_EN.
module delay_checker #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             ref_valid,
    input  logic [WIDTH-1:0] ref_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [15:0]      chk_cnt,
    output logic [7:0]       err_cnt,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DCW = $clog2(DEPTH + 1) + 1;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [DCW-1:0]                drain_cnt_r;
    logic [DEPTH-1:0]              sh_valid_r;
    logic [DEPTH-1:0][WIDTH-1:0]   sh_data_r;
    logic [15:0]                   chk_cnt_r;
    logic [7:0]                    err_cnt_r;
    logic                          err_pulse_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          active_s;
    logic                          accept_s;
    logic                          cmp_s;
    logic                          mism_s;

    // Qualifiers: words are accepted only while armed/checking and not on a stop or restart edge.
    always_comb begin
        active_s = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_ARMED, ST_CHECK: begin
                active_s = 1'b1;
                accept_s = ~stop & ~start;
            end
            ST_DRAIN: begin
                active_s = 1'b1;
                accept_s = 1'b0;
            end
            default: begin
                active_s = 1'b0;
                accept_s = 1'b0;
            end
        endcase
        cmp_s  = sh_valid_r[DEPTH-1] & active_s & ~start;
        mism_s = cmp_s & (dut_out != sh_data_r[DEPTH-1]);
    end

    // Next-state logic; start wins over stop in every active state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_ARMED;
                else       state_nxt_s = ST_IDLE;
            end
            ST_ARMED: begin
                if (start)      state_nxt_s = ST_ARMED;
                else if (stop)  state_nxt_s = ST_DRAIN;
                else if (cmp_s) state_nxt_s = ST_CHECK;
                else            state_nxt_s = ST_ARMED;
            end
            ST_CHECK: begin
                if (start)     state_nxt_s = ST_ARMED;
                else if (stop) state_nxt_s = ST_DRAIN;
                else           state_nxt_s = ST_CHECK;
            end
            ST_DRAIN: begin
                if (start)                           state_nxt_s = ST_ARMED;
                else if (drain_cnt_r == DCW'(DEPTH)) state_nxt_s = ST_DONE;
                else                                 state_nxt_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (start) state_nxt_s = ST_ARMED;
                else       state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, drain timer and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= {DCW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_DRAIN && !start) drain_cnt_r <= drain_cnt_r + DCW'(1);
            else                               drain_cnt_r <= {DCW{1'b0}};
            busy_r <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CHECK) ||
                      (state_nxt_s == ST_DRAIN);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Shadow line mirroring the pipeline under test; a restart drops every word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_valid_r <= {DEPTH{1'b0}};
            sh_data_r  <= {(DEPTH*WIDTH){1'b0}};
        end else begin
            if (start) begin
                sh_valid_r <= {DEPTH{1'b0}};
            end else begin
                sh_valid_r[0] <= ref_valid & accept_s;
                for (int i = 1; i < DEPTH; i++) sh_valid_r[i] <= sh_valid_r[i-1];
            end
            sh_data_r[0] <= ref_in;
            for (int i = 1; i < DEPTH; i++) sh_data_r[i] <= sh_data_r[i-1];
        end
    end

    // Saturating check/error counters and the per-mismatch pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_cnt_r   <= 16'd0;
            err_cnt_r   <= 8'd0;
            err_pulse_r <= 1'b0;
        end else begin
            err_pulse_r <= mism_s;
            if (start) begin
                chk_cnt_r <= 16'd0;
                err_cnt_r <= 8'd0;
            end else if (cmp_s) begin
                if (chk_cnt_r != 16'hFFFF) chk_cnt_r <= chk_cnt_r + 16'd1;
                else                       chk_cnt_r <= chk_cnt_r;
                if (mism_s && err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
                else                              err_cnt_r <= err_cnt_r;
            end else begin
                chk_cnt_r <= chk_cnt_r;
                err_cnt_r <= err_cnt_r;
            end
        end
    end

`ifdef DELAY_CHECKER_FIRST_ERR_EN
    logic [WIDTH-1:0] fe_exp_r;
    logic [WIDTH-1:0] fe_got_r;

    // Capture the first mismatch after a clear; err_cnt still zero marks it as the first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fe_exp_r <= {WIDTH{1'b0}};
            fe_got_r <= {WIDTH{1'b0}};
        end else if (start) begin
            fe_exp_r <= {WIDTH{1'b0}};
            fe_got_r <= {WIDTH{1'b0}};
        end else if (mism_s && err_cnt_r == 8'd0) begin
            fe_exp_r <= sh_data_r[DEPTH-1];
            fe_got_r <= dut_out;
        end else begin
            fe_exp_r <= fe_exp_r;
            fe_got_r <= fe_got_r;
        end
    end

    assign first_err_exp = fe_exp_r;
    assign first_err_got = fe_got_r;
`else
    assign first_err_exp = {WIDTH{1'b0}};
    assign first_err_got = {WIDTH{1'b0}};
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign err_pulse = err_pulse_r;
    assign chk_cnt   = chk_cnt_r;
    assign err_cnt   = err_cnt_r;
    assign pass      = done_r & (err_cnt_r == 8'd0) & (chk_cnt_r != 16'd0);

endmodule

// File: tb/tb_delay_checker.sv
// Directed bench for delay_checker: clean, corrupted, gapped, restart/reset and saturation runs.
module tb_delay_checker;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             ref_valid;
    logic [WIDTH-1:0] ref_in;
    logic [WIDTH-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err_pulse;
    logic [15:0]      chk_cnt;
    logic [7:0]       err_cnt;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_got;

    int n_cmp = 0;
    int n_bad = 0;

    logic             wv [0:319];
    logic [WIDTH-1:0] wd [0:319];
    logic [WIDTH-1:0] wg [0:319];
    logic             pl [0:319];
    logic             dl [0:319];

    delay_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .ref_valid(ref_valid), .ref_in(ref_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start, stream n words (pipeline model returns wg delayed DEPTH edges), stop, drain.
    task automatic run_words(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < n + DEPTH + 2; t++) begin
            ref_valid = (t < n) ? wv[t] : 1'b0;
            ref_in    = (t < n) ? wd[t] : 4'h0;
            if (t >= DEPTH && (t - DEPTH) < n && wv[t-DEPTH]) dut_out = wg[t-DEPTH];
            else                                             dut_out = 4'hF;
            stop = (t == n);
            tick();
            pl[t] = err_pulse;
            dl[t] = done;
        end
        ref_valid = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic load_clean();
        logic [WIDTH-1:0] words [0:9];
        words = '{4'h3, 4'h7, 4'hA, 4'h1, 4'hA, 4'hE, 4'h5, 4'h9, 4'h2, 4'hB};
        for (int i = 0; i < 10; i++) begin
            wv[i] = 1'b1;
            wd[i] = words[i];
            wg[i] = words[i];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, pass, err_pulse, chk_cnt, err_cnt, first_err_exp, first_err_got} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b pass=%0b pulse=%0b chk=%0h err=%0h expected all 0",
                     busy, done, pass, err_pulse, chk_cnt, err_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%0b done=%0b expected 0 0", busy, done);
        end
    endtask

    task automatic test_clean();
        int np;
        load_clean();
        run_words(10);
        np = 0;
        for (int t = 0; t < 16; t++) if (pl[t] === 1'b1) np++;
        n_cmp++;
        if (np != 0) begin
            n_bad++;
            $display("FAIL clean_pulses: got %0d expected 0", np);
        end
        n_cmp++;
        if (dl[14] !== 1'b0 || dl[15] !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_done_timing: got %0b%0b expected 01", dl[14], dl[15]);
        end
        n_cmp++;
        if (chk_cnt !== 16'd10 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL clean_counts: got chk=%0d err=%0d expected 10 0", chk_cnt, err_cnt);
        end
        n_cmp++;
        if (pass !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_pass: got pass=%0b busy=%0b expected 1 0", pass, busy);
        end
    endtask

    task automatic test_corruption();
        int np;
        logic [WIDTH-1:0] exp_e;
        logic [WIDTH-1:0] exp_g;
`ifdef DELAY_CHECKER_FIRST_ERR_EN
        exp_e = 4'hA;
        exp_g = 4'h5;
`else
        exp_e = 4'h0;
        exp_g = 4'h0;
`endif
        load_clean();
        wg[4] = 4'h5;
        run_words(10);
        np = 0;
        for (int t = 0; t < 16; t++) if (pl[t] === 1'b1) np++;
        n_cmp++;
        if (np != 1 || pl[8] !== 1'b1) begin
            n_bad++;
            $display("FAIL corrupt_pulse: got count=%0d pl8=%0b expected 1 1", np, pl[8]);
        end
        n_cmp++;
        if (err_cnt !== 8'd1 || chk_cnt !== 16'd10 || pass !== 1'b0 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL corrupt_counts: got err=%0d chk=%0d pass=%0b done=%0b expected 1 10 0 1",
                     err_cnt, chk_cnt, pass, done);
        end
        n_cmp++;
        if (first_err_exp !== exp_e || first_err_got !== exp_g) begin
            n_bad++;
            $display("FAIL corrupt_first_err: got %0h/%0h expected %0h/%0h",
                     first_err_exp, first_err_got, exp_e, exp_g);
        end
    endtask

    task automatic test_gapped();
        logic [WIDTH-1:0] vals [0:4];
        vals = '{4'h6, 4'h0, 4'h9, 4'h0, 4'hC};
        for (int i = 0; i < 5; i++) begin
            wv[i] = (i % 2 == 0);
            wd[i] = vals[i];
            wg[i] = vals[i];
        end
        run_words(5);
        n_cmp++;
        if (chk_cnt !== 16'd3 || err_cnt !== 8'd0 || pass !== 1'b1) begin
            n_bad++;
            $display("FAIL gapped: got chk=%0d err=%0d pass=%0b expected 3 0 1", chk_cnt, err_cnt, pass);
        end
    endtask

    task automatic test_restart_reset();
        load_clean();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 6; t++) begin
            ref_valid = 1'b1;
            ref_in    = wd[t];
            dut_out   = (t >= DEPTH) ? wd[t-DEPTH] : 4'hF;
            tick();
        end
        ref_valid = 1'b0;
        n_cmp++;
        if (chk_cnt !== 16'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_state: got chk=%0d busy=%0b expected 2 1", chk_cnt, busy);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || chk_cnt !== 16'd0 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%0b done=%0b chk=%0d err=%0d expected 0 0 0 0",
                     busy, done, chk_cnt, err_cnt);
        end
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_words(0);
        n_cmp++;
        if (done !== 1'b1 || chk_cnt !== 16'd0 || pass !== 1'b0 || dl[4] !== 1'b0 || dl[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_run: got done=%0b chk=%0d pass=%0b d4=%0b d5=%0b expected 1 0 0 0 1",
                     done, chk_cnt, pass, dl[4], dl[5]);
        end
    endtask

    task automatic test_saturation();
        int np;
        logic [WIDTH-1:0] exp_g;
`ifdef DELAY_CHECKER_FIRST_ERR_EN
        exp_g = 4'hF;
`else
        exp_g = 4'h0;
`endif
        for (int i = 0; i < 300; i++) begin
            wv[i] = 1'b1;
            wd[i] = i[3:0];
            wg[i] = ~i[3:0];
        end
        run_words(300);
        np = 0;
        for (int t = 4; t < 304; t++) if (pl[t] === 1'b1) np++;
        n_cmp++;
        if (np != 300 || pl[3] !== 1'b0 || pl[304] !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_pulse_run: got %0d high (pl3=%0b pl304=%0b) expected 300 0 0",
                     np, pl[3], pl[304]);
        end
        n_cmp++;
        if (err_cnt !== 8'hFF || chk_cnt !== 16'd300 || pass !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_counts: got err=%0h chk=%0d pass=%0b expected ff 300 0", err_cnt, chk_cnt, pass);
        end
        n_cmp++;
        if (first_err_exp !== 4'h0 || first_err_got !== exp_g) begin
            n_bad++;
            $display("FAIL sat_first_err: got %0h/%0h expected 0/%0h", first_err_exp, first_err_got, exp_g);
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        ref_valid = 1'b0;
        ref_in    = 4'h0;
        dut_out   = 4'h0;
        test_reset();
        test_clean();
        test_corruption();
        test_gapped();
        test_restart_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
